// File: rtl/button_debouncer.sv
// Debounces an already-synchronized button level: the output follows the input only
// after it has differed for STABLE_CYCLES consecutive clocks, with one-cycle edge pulses.
module button_debouncer #(
  parameter int unsigned STABLE_CYCLES = 250000,
  parameter logic        INIT_VALUE    = 1'b0
) (
  input  logic clk_in,
  input  logic reset_in,
  input  logic signal_in,
  output logic signal_out,
  output logic is_rising_out,
  output logic is_falling_out
);

  localparam int unsigned CW = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] LP_LAST = CW'(STABLE_CYCLES - 1);

  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_rise;
  logic          r_fall;

  logic w_differs;
  logic w_qualified;

  assign w_differs   = (signal_in != r_level);
  assign w_qualified = w_differs && (r_cnt == LP_LAST);

  // Any sample matching the current level restarts qualification from zero,
  // so the counter tops out at STABLE_CYCLES-1 and never wraps.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      r_level <= INIT_VALUE;
      r_cnt   <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else if (!w_differs) begin
      r_cnt  <= '0;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else if (w_qualified) begin
      r_level <= signal_in;
      r_cnt   <= '0;
      r_rise  <= signal_in;
      r_fall  <= ~signal_in;
    end else begin
      r_cnt  <= r_cnt + 1'b1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end
  end

  assign signal_out     = r_level;
  assign is_rising_out  = r_rise;
  assign is_falling_out = r_fall;

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer: a STABLE_CYCLES=4 instance for reset, press,
// bounce, release and mid-qualification reset, and a STABLE_CYCLES=1 instance for toggling.
module tb_button_debouncer;

  logic clk;
  logic rst;
  logic sig4;
  logic sig1;
  logic out4, rise4, fall4;
  logic out1, rise1, fall1;

  int n_checks = 0;
  int n_errors = 0;

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  button_debouncer #(.STABLE_CYCLES(4), .INIT_VALUE(1'b0)) u_dut4 (
    .clk_in         (clk),
    .reset_in       (rst),
    .signal_in      (sig4),
    .signal_out     (out4),
    .is_rising_out  (rise4),
    .is_falling_out (fall4)
  );

  button_debouncer #(.STABLE_CYCLES(1), .INIT_VALUE(1'b0)) u_dut1 (
    .clk_in         (clk),
    .reset_in       (rst),
    .signal_in      (sig1),
    .signal_out     (out1),
    .is_rising_out  (rise1),
    .is_falling_out (fall1)
  );

  task automatic check_eq(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, obs, exp);
    end
  endtask

  // One active edge, then settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive the STABLE_CYCLES=4 instance for one edge and check all three outputs.
  task automatic drive4(input string tag, input logic s, input logic e_out,
                        input logic e_rise, input logic e_fall);
    sig4 = s;
    tick();
    check_eq({tag, ".out"},  out4,  e_out);
    check_eq({tag, ".rise"}, rise4, e_rise);
    check_eq({tag, ".fall"}, fall4, e_fall);
  endtask

  initial begin
    logic [7:0] bounce;
    rst  = 1'b1;
    sig4 = 1'b1;
    sig1 = 1'b1;

    // 1. Reset held two cycles with input high
    for (int i = 0; i < 2; i++) begin
      tick();
      check_eq("rst.out4",  out4,  1'b0);
      check_eq("rst.rise4", rise4, 1'b0);
      check_eq("rst.fall4", fall4, 1'b0);
      check_eq("rst.out1",  out1,  1'b0);
    end
    rst  = 1'b0;
    sig1 = 1'b0;
    drive4("post_rst", 1'b0, 1'b0, 1'b0, 1'b0);

    // 2. Clean press: rises on the 4th edge seeing 1
    drive4("press1", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("press2", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("press3", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("press4", 1'b1, 1'b1, 1'b1, 1'b0);
    drive4("press5", 1'b1, 1'b1, 1'b0, 1'b0);

    // 4. Clean release
    drive4("rel1", 1'b0, 1'b1, 1'b0, 1'b0);
    drive4("rel2", 1'b0, 1'b1, 1'b0, 1'b0);
    drive4("rel3", 1'b0, 1'b1, 1'b0, 1'b0);
    drive4("rel4", 1'b0, 1'b0, 1'b0, 1'b1);
    drive4("rel5", 1'b0, 1'b0, 1'b0, 1'b0);

    // 3. Bounce 1,1,1,0,1,1,1,0 never reaches the output; then a steady run rises
    bounce = 8'b0111_0111;
    for (int i = 0; i < 8; i++)
      drive4($sformatf("bounce%0d", i), bounce[i], 1'b0, 1'b0, 1'b0);
    drive4("steady1", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("steady2", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("steady3", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("steady4", 1'b1, 1'b1, 1'b1, 1'b0);
    drive4("release_a", 1'b0, 1'b1, 1'b0, 1'b0);
    drive4("release_b", 1'b0, 1'b1, 1'b0, 1'b0);
    drive4("release_c", 1'b0, 1'b1, 1'b0, 1'b0);
    drive4("release_d", 1'b0, 1'b0, 1'b0, 1'b1);

    // 5. Reset after three qualifying samples: no rise, restart afterwards
    drive4("midq1", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("midq2", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("midq3", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    drive4("midq_rst", 1'b1, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;
    drive4("after1", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("after2", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("after3", 1'b1, 1'b0, 1'b0, 1'b0);
    drive4("after4", 1'b1, 1'b1, 1'b1, 1'b0);

    // 6. STABLE_CYCLES=1: output mirrors input one cycle late, pulses alternate
    for (int i = 0; i < 8; i++) begin
      sig1 = (i % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      check_eq($sformatf("tog%0d.out", i),  out1,  sig1);
      check_eq($sformatf("tog%0d.rise", i), rise1, sig1);
      check_eq($sformatf("tog%0d.fall", i), fall1, ~sig1);
      check_eq($sformatf("tog%0d.excl", i), rise1 & fall1, 1'b0);
    end
    tick();
    check_eq("tog_hold.out",  out1,  1'b0);
    check_eq("tog_hold.fall", fall1, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
